// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and op-class helpers for multicycle_alu (ALU_SIGNED_MULDIV_EN adds MULH/DIV/REM)
package alu_pkg;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3, OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_OR = 5'd8, OP_AND = 5'd9;
  localparam logic [4:0] OP_MUL = 5'd10, OP_MULHU = 5'd11, OP_DIVU = 5'd12, OP_REMU = 5'd13;
`ifdef ALU_SIGNED_MULDIV_EN
  localparam logic [4:0] OP_MULH = 5'd14, OP_DIV = 5'd15, OP_REM = 5'd16;
`endif
  typedef enum logic [1:0] {IDLE, MULT, DIV, OUT} state_t;
  function automatic logic is_div(input logic [4:0] op);
`ifdef ALU_SIGNED_MULDIV_EN
    return op == OP_DIVU || op == OP_REMU || op == OP_DIV || op == OP_REM;
`else
    return op == OP_DIVU || op == OP_REMU;
`endif
  endfunction
  function automatic logic is_muldiv(input logic [4:0] op);
`ifdef ALU_SIGNED_MULDIV_EN
    return is_div(op) || op == OP_MUL || op == OP_MULHU || op == OP_MULH;
`else
    return is_div(op) || op == OP_MUL || op == OP_MULHU;
`endif
  endfunction
`ifdef ALU_SIGNED_MULDIV_EN
  function automatic logic is_sgn(input logic [4:0] op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction
`endif
endpackage

// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/response bundle between an issuing stage and multicycle_alu
interface multicycle_alu_if #(parameter int XLEN = 32);
  logic valid;
  logic [4:0] alu_op;
  logic [XLEN-1:0] in_a, in_b, result;
  logic busy, ready, zero;
  modport master(output valid, alu_op, in_a, in_b, input busy, ready, result, zero);
  modport slave(input valid, alu_op, in_a, in_b, output busy, ready, result, zero);
endinterface

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: radix-2 shift-add multiplier / restoring divider, XLEN iterations per start
module seq_muldiv_unit #(parameter int XLEN = 32) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic done,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);
  localparam int SHW = $clog2(XLEN);
  logic run, mode;
  logic [SHW-1:0] cnt;
  logic [XLEN-1:0] hi, lo, opd;
  logic [XLEN:0] sum, shf, dif;
  assign sum = {1'b0, hi} + {1'b0, (lo[0] ? opd : {XLEN{1'b0}})};
  assign shf = {hi, lo[XLEN-1]};
  assign dif = shf - {1'b0, opd};
  assign done = run && cnt == SHW'(XLEN - 1);
  assign prod = {hi, lo};
  assign quot = lo;
  assign rem = hi;
  // hi:lo is the product accumulator for multiply and remainder:quotient for divide
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      mode <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      opd <= '0;
    end else if (start) begin
      run <= 1'b1;
      mode <= div;
      cnt <= '0;
      hi <= '0;
      lo <= div ? a : b;
      opd <= div ? b : a;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      run <= !done;
      hi <= mode ? (dif[XLEN] ? shf[XLEN-1:0] : dif[XLEN-1:0]) : sum[XLEN:1];
      lo <= mode ? {lo[XLEN-2:0], !dif[XLEN]} : {sum[0], lo[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: XLEN-bit ALU with single-cycle ops and iterative mul/div on one handshake
// ALU_SIGNED_MULDIV_EN enables MULH/DIV/REM via magnitude operands and sign fix-up at output.
module multicycle_alu import alu_pkg::*; #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  multicycle_alu_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  state_t state, nxt;
  logic [4:0] op;
  logic [XLEN-1:0] a, b, mag_a, mag_b, nres, quot, rem, result;
  logic [2*XLEN-1:0] prod;
  logic done, accept, ready, zero;
  assign accept = state == IDLE && bus.valid;
  assign bus.busy = state != IDLE || ready;
  assign bus.ready = ready;
  assign bus.result = result;
  assign bus.zero = zero;
`ifdef ALU_SIGNED_MULDIV_EN
  logic sgn;
  logic [2*XLEN-1:0] sprod;
  assign sgn = is_sgn(bus.alu_op);
  assign mag_a = sgn && bus.in_a[XLEN-1] ? -bus.in_a : bus.in_a;
  assign mag_b = sgn && bus.in_b[XLEN-1] ? -bus.in_b : bus.in_b;
  assign sprod = a[XLEN-1] ^ b[XLEN-1] ? -prod : prod;
`else
  assign mag_a = bus.in_a;
  assign mag_b = bus.in_b;
`endif
  seq_muldiv_unit #(.XLEN(XLEN)) u_md (
    .clk(clk), .rst(rst), .start(accept && is_muldiv(bus.alu_op)), .div(is_div(bus.alu_op)),
    .a(mag_a), .b(mag_b), .done(done), .prod(prod), .quot(quot), .rem(rem)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (bus.valid ? (is_div(bus.alu_op) ? DIV : is_muldiv(bus.alu_op) ? MULT : OUT) : IDLE)
        : state == OUT ? IDLE : done ? OUT : state;
  end
  always_comb begin
    nres = '0;
    case (op)
      OP_ADD: nres = a + b;
      OP_SUB: nres = a - b;
      OP_SLL: nres = a << b[SHW-1:0];
      OP_SLT: nres = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: nres = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR: nres = a ^ b;
      OP_SRL: nres = a >> b[SHW-1:0];
      OP_SRA: nres = $unsigned($signed(a) >>> b[SHW-1:0]);
      OP_OR: nres = a | b;
      OP_AND: nres = a & b;
      OP_MUL: nres = prod[XLEN-1:0];
      OP_MULHU: nres = prod[2*XLEN-1:XLEN];
      OP_DIVU: nres = quot;
      OP_REMU: nres = rem;
`ifdef ALU_SIGNED_MULDIV_EN
      OP_MULH: nres = sprod[2*XLEN-1:XLEN];
      OP_DIV: nres = (a[XLEN-1] ^ b[XLEN-1]) && b != '0 ? -quot : quot;
      OP_REM: nres = a[XLEN-1] ? -rem : rem;
`endif
      default: nres = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= '0;
      a <= '0;
      b <= '0;
      ready <= 1'b0;
      result <= '0;
      zero <= 1'b1;
    end else begin
      if (accept) begin
        op <= bus.alu_op;
        a <= bus.in_a;
        b <= bus.in_b;
      end
      ready <= state == OUT;
      if (state == OUT) begin
        result <= nres;
        zero <= nres == '0;
      end
    end
  end
endmodule
